game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/game_fsm.sv | 191 +++++++++++++++++++
 tb/tb_game_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm.sv
// Top-level game flow controller: menu/start/play/pause/lose/win sequencing,
// frame-rate tick generation and a saturating win counter, all registered.
module game_fsm #(
    parameter int CLK_HZ          = 65_000_000,
    parameter int FPS             = 60,
    parameter int END_HOLD_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       player_dead,
    input  logic       boss_dead,
    output logic [1:0] game_active,
    output logic       game_start,
    output logic       paused,
    output logic       frame_tick,
    output logic [3:0] rounds_won
);

    localparam int FRAME_TICKS = CLK_HZ / FPS;
    localparam int FC_W        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int HOLD_W      = (END_HOLD_FRAMES > 0) ? $clog2(END_HOLD_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_START = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_LOSE  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              start_q_r;
    logic              pause_q_r;
    logic              start_press_s;
    logic              pause_press_s;
    logic [FC_W-1:0]   frame_cnt_r;
    logic              frame_tick_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              end_state_s;
    logic              end_entry_s;
    logic              hold_done_s;
    logic              win_entry_s;
    logic [1:0]        active_r;
    logic              start_pulse_r;
    logic              paused_r;
    logic [3:0]        rounds_r;

    // Output decode of a state value; shared by the registered output path.
    function automatic logic [1:0] decode_active(input state_t st);
        logic [1:0] act;
        case (st)
            ST_PLAY: act = 2'd1;
            ST_LOSE: act = 2'd2;
            ST_WIN:  act = 2'd3;
            default: act = 2'd0;
        endcase
        return act;
    endfunction

    // Rising-edge detect on both keys.
    always_comb begin
        start_press_s = btn_start & ~start_q_r;
        pause_press_s = btn_pause & ~pause_q_r;
    end

    // Key history; reset to 1 so a key held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q_r <= 1'b1;
            pause_q_r <= 1'b1;
        end else begin
            start_q_r <= btn_start;
            pause_q_r <= btn_pause;
        end
    end

    // Free-running frame divider with registered one-cycle tick per wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_r  <= '0;
            frame_tick_r <= 1'b0;
        end else if (frame_cnt_r == FC_W'(FRAME_TICKS - 1)) begin
            frame_cnt_r  <= '0;
            frame_tick_r <= 1'b1;
        end else begin
            frame_cnt_r  <= frame_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
            frame_tick_r <= 1'b0;
        end
    end

    // End-screen bookkeeping: timeout fires on the tick that completes the hold.
    always_comb begin
        end_state_s = (state_r == ST_LOSE) || (state_r == ST_WIN);
        hold_done_s = frame_tick_r && (hold_cnt_r == HOLD_W'(END_HOLD_FRAMES - 1));
        end_entry_s = ((state_next_s == ST_LOSE) || (state_next_s == ST_WIN)) && !end_state_s;
        win_entry_s = (state_r == ST_PLAY) && (state_next_s == ST_WIN);
    end

    // Next-state logic; death outranks boss kill, which outranks pause.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_MENU: begin
                if (start_press_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_MENU;
                end
            end
            ST_START: state_next_s = ST_PLAY;
            ST_PLAY: begin
                if (player_dead) begin
                    state_next_s = ST_LOSE;
                end else if (boss_dead) begin
                    state_next_s = ST_WIN;
                end else if (pause_press_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (pause_press_s) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_LOSE, ST_WIN: begin
                if (start_press_s) begin
                    state_next_s = ST_START;
                end else if (hold_done_s) begin
                    state_next_s = ST_MENU;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_MENU;
        endcase
    end

    // State register with outputs registered from the same next-state value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_MENU;
            active_r      <= 2'd0;
            start_pulse_r <= 1'b0;
            paused_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            active_r      <= decode_active(state_next_s);
            start_pulse_r <= (state_next_s == ST_START);
            paused_r      <= (state_next_s == ST_PAUSE);
        end
    end

    // Hold counter: cleared on entry, counts ticks while on an end screen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= '0;
        end else if (end_entry_s) begin
            hold_cnt_r <= '0;
        end else if (end_state_s && frame_tick_r && (hold_cnt_r != HOLD_W'(END_HOLD_FRAMES))) begin
            hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Saturating win counter; survives new rounds, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rounds_r <= 4'd0;
        end else if (win_entry_s && (rounds_r != 4'd15)) begin
            rounds_r <= rounds_r + 4'd1;
        end else begin
            rounds_r <= rounds_r;
        end
    end

    assign game_active = active_r;
    assign game_start  = start_pulse_r;
    assign paused      = paused_r;
    assign frame_tick  = frame_tick_r;
    assign rounds_won  = rounds_r;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: directed scenarios with literal expectations
// plus randomized play compared every cycle against a behavioural model.
module tb_game_fsm;

    localparam int CLK_HZ = 240;
    localparam int FPS    = 60;
    localparam int FT     = CLK_HZ / FPS;
    localparam int HOLD   = 3;

    localparam int M_MENU  = 0;
    localparam int M_START = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_LOSE  = 4;
    localparam int M_WIN   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       player_dead = 1'b0;
    logic       boss_dead = 1'b0;
    logic [1:0] game_active;
    logic       game_start;
    logic       paused;
    logic       frame_tick;
    logic [3:0] rounds_won;

    int n_checks = 0;
    int n_pass   = 0;

    int m_mode  = M_MENU;
    int m_n     = 0;
    int m_hold  = 0;
    int m_wins  = 0;
    bit m_tick  = 1'b0;
    bit m_ps    = 1'b1;
    bit m_pp    = 1'b1;
    bit m_valid = 1'b0;

    game_fsm #(.CLK_HZ(CLK_HZ), .FPS(FPS), .END_HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .player_dead(player_dead), .boss_dead(boss_dead), .game_active(game_active),
        .game_start(game_start), .paused(paused), .frame_tick(frame_tick),
        .rounds_won(rounds_won)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_active(input int mode);
        if (mode == M_PLAY) return 1;
        if (mode == M_LOSE) return 2;
        if (mode == M_WIN) return 3;
        return 0;
    endfunction

    // Behavioural model, advanced once per rising edge from the sampled inputs.
    task model_step();
        int nx;
        int seen;
        bit sp;
        bit pp;
        if (!rst_n) begin
            m_mode = M_MENU; m_n = 0; m_tick = 1'b0; m_hold = 0; m_wins = 0;
            m_ps = 1'b1; m_pp = 1'b1; m_valid = 1'b1;
        end else begin
            sp = btn_start && !m_ps;
            pp = btn_pause && !m_pp;
            nx = m_mode;
            if (m_mode == M_MENU && sp) nx = M_START;
            else if (m_mode == M_START) nx = M_PLAY;
            else if (m_mode == M_PLAY) begin
                if (player_dead) nx = M_LOSE;
                else if (boss_dead) nx = M_WIN;
                else if (pp) nx = M_PAUSE;
            end else if (m_mode == M_PAUSE && pp) nx = M_PLAY;
            else if (m_mode == M_LOSE || m_mode == M_WIN) begin
                seen = m_hold + (m_tick ? 1 : 0);
                m_hold = seen;
                if (sp) nx = M_START;
                else if (seen >= HOLD) nx = M_MENU;
            end
            if (m_mode == M_PLAY && (nx == M_LOSE || nx == M_WIN)) m_hold = 0;
            if (m_mode == M_PLAY && nx == M_WIN && m_wins < 15) m_wins++;
            m_mode = nx;
            m_n++;
            m_tick = (m_n % FT) == 0;
            m_ps = btn_start;
            m_pp = btn_pause;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("game_active", int'(game_active), exp_active(m_mode));
                check("game_start", int'(game_start), int'(m_mode == M_START));
                check("paused", int'(paused), int'(m_mode == M_PAUSE));
                check("frame_tick", int'(frame_tick), int'(m_tick));
                check("rounds_won", int'(rounds_won), m_wins);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int ticks;
        int k;
        step();
        step();
        check("reset_active", int'(game_active), 0);
        check("reset_rounds", int'(rounds_won), 0);
        check("reset_tick", int'(frame_tick), 0);

        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("idle_tick_pattern", int'(frame_tick), int'((i % 4) == 0));
            check("idle_active", int'(game_active), 0);
        end

        btn_start = 1'b1;
        step();
        check("start_pulse", int'(game_start), 1);
        pulses = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            pulses += int'(game_start);
        end
        check("start_pulse_count", pulses, 1);
        check("play_after_start", int'(game_active), 1);
        btn_start = 1'b0;

        btn_pause = 1'b1; player_dead = 1'b1; boss_dead = 1'b1;
        step();
        check("double_death_lose", int'(game_active), 2);
        check("double_death_paused", int'(paused), 0);
        check("double_death_rounds", int'(rounds_won), 0);
        btn_pause = 1'b0; player_dead = 1'b0; boss_dead = 1'b0;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        check("restart_play", int'(game_active), 1);

        btn_pause = 1'b1;
        step();
        check("pause_paused", int'(paused), 1);
        check("pause_active", int'(game_active), 0);
        btn_pause = 1'b0; boss_dead = 1'b1;
        step();
        step();
        check("pause_ignores_boss", int'(paused), 1);
        btn_pause = 1'b1;
        step();
        check("unpause_active", int'(game_active), 1);
        step();
        check("win_after_unpause", int'(game_active), 3);
        check("win_rounds", int'(rounds_won), 1);
        btn_pause = 1'b0; boss_dead = 1'b0;

        ticks = 0;
        k = 0;
        while (game_active != 2'd0 && k < 40) begin
            if (frame_tick && game_active == 2'd3) ticks++;
            step();
            k++;
        end
        check("win_timeout_menu", int'(game_active), 0);
        check("win_ticks_before_menu", ticks, 3);

        for (int i = 0; i < 15; i++) begin
            btn_start = 1'b1;
            step();
            btn_start = 1'b0;
            step();
            boss_dead = 1'b1;
            step();
            boss_dead = 1'b0;
        end
        check("rounds_saturate", int'(rounds_won), 15);

        btn_start = 1'b1; rst_n = 1'b0;
        step();
        check("held_reset_active", int'(game_active), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_no_start", int'(game_start), 0);
        end
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        check("repress_start", int'(game_start), 1);
        btn_start = 1'b0;
        step();
        check("repress_play", int'(game_active), 1);
        rst_n = 1'b0;
        step();
        check("midgame_reset_active", int'(game_active), 0);
        check("midgame_reset_start", int'(game_start), 0);
        check("midgame_reset_paused", int'(paused), 0);
        check("midgame_reset_tick", int'(frame_tick), 0);
        check("midgame_reset_rounds", int'(rounds_won), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 3) == 0) btn_pause = ~btn_pause;
            player_dead = ($urandom_range(0, 29) == 0);
            boss_dead   = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
